// File: rtl/multiplexer_pkg.sv
// Shared constants and helpers for the scanning N-to-1 word multiplexer.
// Mode encodings plus the select-width helper used by every block.
package multiplexer_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Width of a field able to index n items; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_counter.sv
// Channel/dwell sequencer for scan mode; load overrides stepping (manual tracking).
// State moves only on enabled edges; wrap_next flags "last enabled edge wrapped to channel 0".
module scan_counter
  import multiplexer_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DWELL    = 1,
  localparam int SEL_W   = sel_width(CHANNELS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic [SEL_W-1:0] load_val,
  output logic [SEL_W-1:0] ch,
  output logic             wrap_next
);

  localparam int               DW_W       = sel_width(DWELL);
  localparam logic [SEL_W-1:0] LP_CH_LAST = SEL_W'(CHANNELS - 1);
  localparam logic [DW_W-1:0]  LP_DW_LAST = DW_W'(DWELL - 1);

  logic [SEL_W-1:0] r_ch;
  logic [DW_W-1:0]  r_dwell;
  logic             r_wrapped;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ch      <= '0;
      r_dwell   <= '0;
      r_wrapped <= 1'b0;
    end else if (enable) begin
      if (load) begin
        r_ch      <= load_val;
        r_dwell   <= '0;
        r_wrapped <= 1'b0;
      end else if (r_dwell == LP_DW_LAST) begin
        r_dwell <= '0;
        if (r_ch == LP_CH_LAST) begin
          r_ch      <= '0;
          r_wrapped <= 1'b1;
        end else begin
          r_ch      <= r_ch + SEL_W'(1);
          r_wrapped <= 1'b0;
        end
      end else begin
        r_dwell   <= r_dwell + DW_W'(1);
        r_wrapped <= 1'b0;
      end
    end
  end

  assign ch        = r_ch;
  assign wrap_next = r_wrapped;

endmodule

// File: rtl/multiplexer_scan_nto1.sv
// Registered N-to-1 word mux, manual select or autonomous scan; one-cycle latency.
// No backpressure: enable low freezes state and drops out_valid/wrap.
module multiplexer_scan_nto1
  import multiplexer_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 1,
  localparam int SEL_W   = sel_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_bus,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid,
  output logic                      wrap
);

  logic             w_scan;
  logic             w_legal;
  logic             w_cap;
  logic             w_wrap_next;
  logic [SEL_W-1:0] w_ch;
  logic [SEL_W-1:0] w_src;
  logic [WIDTH-1:0] w_data;

  logic [WIDTH-1:0] r_out;
  logic [SEL_W-1:0] r_out_ch;
  logic             r_valid;
  logic             r_wrap;
  logic             r_mode_q;

  generate
    if ((1 << SEL_W) == CHANNELS) begin : g_full
      assign w_legal = 1'b1;
    end else begin : g_partial
      assign w_legal = ({1'b0, sel} < (SEL_W + 1)'(CHANNELS));
    end
  endgenerate

  assign w_scan = (mode == MODE_SCAN);
  // An illegal manual select falls back to the held channel, which also keeps ch in place.
  assign w_src  = (w_scan || !w_legal) ? w_ch : sel;
  assign w_cap  = w_scan || w_legal;
  assign w_data = in_bus[int'(w_src) * WIDTH +: WIDTH];

  scan_counter #(
    .CHANNELS (CHANNELS),
    .DWELL    (DWELL)
  ) u_scan_counter (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .load      (!w_scan),
    .load_val  (w_src),
    .ch        (w_ch),
    .wrap_next (w_wrap_next)
  );

  // wrap lines up with the first sample of channel 0 after a wrap, never on scan entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out    <= '0;
      r_out_ch <= '0;
      r_valid  <= 1'b0;
      r_wrap   <= 1'b0;
      r_mode_q <= MODE_MANUAL;
    end else begin
      r_mode_q <= mode;
      if (enable) begin
        r_valid <= w_cap;
        r_wrap  <= w_scan && (r_mode_q == MODE_SCAN) && w_wrap_next;
        if (w_cap) begin
          r_out    <= w_data;
          r_out_ch <= w_src;
        end
      end else begin
        r_valid <= 1'b0;
        r_wrap  <= 1'b0;
      end
    end
  end

  assign out       = r_out;
  assign out_ch    = r_out_ch;
  assign out_valid = r_valid;
  assign wrap      = r_wrap;

endmodule

// File: tb/tb_multiplexer_scan_nto1.sv
// Scoreboard bench: two instances (4ch/dwell 2 and 3ch/dwell 1) against an arithmetic scan model.
module tb_multiplexer_scan_nto1;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        mode;
  logic [1:0]  sel0, sel1;
  logic [31:0] bus0;
  logic [23:0] bus1;
  logic [7:0]  out0, out1;
  logic [1:0]  och0, och1;
  logic        ov0, ov1, wr0, wr1;

  always #5 clk = ~clk;

  multiplexer_scan_nto1 #(.WIDTH(8), .CHANNELS(4), .DWELL(2)) u_dut0 (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .sel(sel0), .in_bus(bus0),
    .out(out0), .out_ch(och0), .out_valid(ov0), .wrap(wr0)
  );

  multiplexer_scan_nto1 #(.WIDTH(8), .CHANNELS(3), .DWELL(1)) u_dut1 (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .sel(sel1), .in_bus(bus1),
    .out(out1), .out_ch(och1), .out_valid(ov1), .wrap(wr1)
  );

  typedef struct {
    logic [7:0] dat;
    int         ch;
    logic       wrap;
    int         cyc;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  int         nch[2] = '{4, 3};
  int         ndw[2] = '{2, 1};
  logic [7:0] d[2][4];
  int         s[2];
  int         k[2];
  logic       pm[2];
  logic [7:0] hd[2];
  int         hc[2];
  int         edge_n = 0;
  int         n_chk  = 0;
  int         n_pass = 0;

  assign bus0 = {d[0][3], d[0][2], d[0][1], d[0][0]};
  assign bus1 = {d[1][2], d[1][1], d[1][0]};

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Scan position = start channel + (enabled scan samples so far) / dwell, modulo channel count.
  task automatic model_edge(input int i, input logic en, input logic md, input int sl);
    exp_t e;
    int   c;
    if (en) begin
      if (md == 1'b0) begin
        if (sl < nch[i]) begin
          e.dat = d[i][sl]; e.ch = sl; e.wrap = 1'b0; e.cyc = edge_n + 1;
          if (i == 0) q0.push_back(e); else q1.push_back(e);
          s[i] = sl;
        end else begin
          s[i] = (s[i] + k[i] / ndw[i]) % nch[i];
        end
        k[i] = 0;
      end else begin
        c = (s[i] + k[i] / ndw[i]) % nch[i];
        e.dat  = d[i][c];
        e.ch   = c;
        e.wrap = pm[i] && (k[i] > 0) && (k[i] % ndw[i] == 0) && (c == 0);
        e.cyc  = edge_n + 1;
        if (i == 0) q0.push_back(e); else q1.push_back(e);
        k[i]++;
      end
    end
    pm[i] = md;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      s[i] = 0; k[i] = 0; pm[i] = 1'b0; hd[i] = 8'h00; hc[i] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic rand_data();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 4; j++)
        d[i][j] = 8'($urandom);
  endtask

  // Sets inputs for the coming edge, records the expectation, returns 2 time units after the edge.
  task automatic drive(input logic en, input logic md, input logic [1:0] s0, input logic [1:0] s1);
    enable = en; mode = md; sel0 = s0; sel1 = s1;
    model_edge(0, en, md, int'(s0));
    model_edge(1, en, md, int'(s1));
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out0"}, out0, 0);  chk({tag, "_och0"}, och0, 0);
    chk({tag, "_ov0"},  ov0,  0);  chk({tag, "_wr0"},  wr0,  0);
    chk({tag, "_out1"}, out1, 0);  chk({tag, "_och1"}, och1, 0);
    chk({tag, "_ov1"},  ov1,  0);  chk({tag, "_wr1"},  wr1,  0);
  endtask

  // Asserts reset between edges and checks the outputs clear before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    enable = 1'b0;
    #1 check_reset_outputs("async_rst");
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic mon(input int i, input logic v, input logic [7:0] o, input logic [1:0] oc, input logic w);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (i == 0 && q0.size() > 0) begin e = q0[0]; have = 1'b1; end
    if (i == 1 && q1.size() > 0) begin e = q1[0]; have = 1'b1; end
    if (have && e.cyc <= edge_n) begin
      if (i == 0) e = q0.pop_front(); else e = q1.pop_front();
      chk($sformatf("u%0d_valid", i), v, 1);
      chk($sformatf("u%0d_data", i), o, e.dat);
      chk($sformatf("u%0d_ch", i), oc, e.ch);
      chk($sformatf("u%0d_wrap", i), w, e.wrap);
      hd[i] = e.dat;
      hc[i] = e.ch;
    end else begin
      chk($sformatf("u%0d_idle_valid", i), v, 0);
      chk($sformatf("u%0d_hold_data", i), o, hd[i]);
      chk($sformatf("u%0d_hold_ch", i), oc, hc[i]);
      chk($sformatf("u%0d_idle_wrap", i), w, 0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, ov0, out0, och0, wr0);
      mon(1, ov1, out1, och1, wr1);
    end
  end

  int         scan_seq[9]  = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  int         gap_seq[6]   = '{0, 0, 1, 1, 2, 2};
  int         sw_seq0[3]   = '{3, 3, 0};
  int         sw_seq1[3]   = '{1, 2, 0};
  logic       rmode;
  logic [7:0] keep1;

  initial begin
    rst = 1'b1; enable = 1'b0; mode = 1'b0; sel0 = 2'd0; sel1 = 2'd0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 4; j++)
        d[i][j] = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #2 check_reset_outputs("por");
    rst = 1'b0;

    // Manual select of channel 2.
    rand_data();
    d[0][0] = 8'h11; d[0][1] = 8'h22; d[0][2] = 8'h33; d[0][3] = 8'h44;
    drive(1'b1, 1'b0, 2'd2, 2'd1);
    chk("manual_out", out0, 8'h33);
    chk("manual_och", och0, 2);
    chk("manual_ov", ov0, 1);

    // Async reset while out holds A5.
    d[0][2] = 8'hA5;
    drive(1'b1, 1'b0, 2'd2, 2'd0);
    chk("pre_rst_out", out0, 8'hA5);
    do_reset();

    // Scan from reset.
    for (int i = 0; i < 9; i++) begin
      rand_data();
      drive(1'b1, 1'b1, 2'd0, 2'd0);
      chk($sformatf("scan_seq_ch[%0d]", i), och0, scan_seq[i]);
      chk($sformatf("scan_seq_wrap[%0d]", i), wr0, (i == 8) ? 1 : 0);
    end

    // Enable gap mid-dwell on channel 1.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        for (int g = 0; g < 3; g++) begin
          drive(1'b0, 1'b1, 2'd0, 2'd0);
          chk("gap_ov", ov0, 0);
          chk("gap_wrap", wr0, 0);
        end
      end
      rand_data();
      drive(1'b1, 1'b1, 2'd0, 2'd0);
      chk($sformatf("gap_seq_ch[%0d]", i), och0, gap_seq[i]);
    end

    // Manual at 3 (illegal 3 on the 3-channel instance), then scan, then back to manual.
    rand_data();
    drive(1'b1, 1'b0, 2'd3, 2'd1);
    keep1 = d[1][1];
    rand_data();
    drive(1'b1, 1'b0, 2'd3, 2'd3);
    chk("illegal_ov1", ov1, 0);
    chk("illegal_hold1", out1, keep1);
    for (int i = 0; i < 3; i++) begin
      rand_data();
      drive(1'b1, 1'b1, 2'd0, 2'd0);
      chk($sformatf("sw_ch0[%0d]", i), och0, sw_seq0[i]);
      chk($sformatf("sw_wrap0[%0d]", i), wr0, (i == 2) ? 1 : 0);
      chk($sformatf("sw_ch1[%0d]", i), och1, sw_seq1[i]);
      chk($sformatf("sw_wrap1[%0d]", i), wr1, (i == 2) ? 1 : 0);
    end
    rand_data();
    drive(1'b1, 1'b0, 2'd1, 2'd2);
    chk("back_manual_och0", och0, 1);

    // Randomized traffic with one mid-run reset.
    rmode = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset();
      if ($urandom_range(7) == 0) rmode = ~rmode;
      rand_data();
      drive(($urandom_range(4) != 0), rmode, 2'($urandom_range(3)), 2'($urandom_range(3)));
    end

    repeat (3) drive(1'b0, rmode, 2'd0, 2'd0);
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multiplexer_scan_nto1.md
Name: multiplexer_scan_nto1

Overview:
- Parametrised, registered N-to-1 word multiplexer: CHANNELS inputs, each WIDTH bits wide.
- Two modes:
  - Manual: external select chooses the channel.
  - Scan: an internal counter steps through all channels, holding each for DWELL enabled cycles.
- Sits between multi-channel sources and a single shared consumer, e.g. a time-division readout or display path.
- Generalises the 2:1 and 4:1 combinational muxes with width, channel count, registered output and autonomous sequencing.

Parameters:
- WIDTH, 8, data bits per channel (>=1).
- CHANNELS, 4, number of input channels (>=2).
- DWELL, 1, enabled cycles spent on each channel in scan mode (>=1).
- SEL_W, $clog2(CHANNELS), localparam, width of select and channel fields.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  advance/capture qualifier; low freezes all state.
- mode  input  1  0 = manual, 1 = scan.
- sel  input  SEL_W  manual-mode channel select.
- in_bus  input  CHANNELS*WIDTH  packed inputs; channel k occupies bits [k*WIDTH +: WIDTH].
- out  output  WIDTH  registered selected data.
- out_ch  output  SEL_W  channel index that produced the current out.
- out_valid  output  1  out/out_ch were captured on the previous edge.
- wrap  output  1  one-cycle pulse when scan passes CHANNELS-1 -> 0.

Behaviour:
- Reset (rst=1, async, no clock needed): out=0, out_ch=0, out_valid=0, wrap=0. Internal ch=0, dwell=0, mode_q=0.
  - Deassertion is sampled normally; first capture happens on the first edge with enable=1.
- Latency: one cycle. Data present at edge t appears on out after edge t; out_ch is registered in the same edge.
- enable=0: out and out_ch hold; ch and dwell freeze; out_valid<=0; wrap<=0.
- Manual (mode=1'b0, enable=1):
  - sel<CHANNELS: out<=in_bus[sel], out_ch<=sel, out_valid<=1.
  - sel>=CHANNELS (non-power-of-two CHANNELS only): out/out_ch hold, out_valid<=0.
  - wrap<=0; dwell<=0; ch tracks sel when sel is legal.
- Scan (mode=1, enable=1):
  - out<=in_bus[ch], out_ch<=ch, out_valid<=1.
  - If dwell==DWELL-1: dwell<=0 and ch<=(ch==CHANNELS-1)?0:ch+1. Otherwise dwell<=dwell+1.
  - wrap<=1 on the edge where ch goes from CHANNELS-1 to 0; else 0.
- Mode transitions, detected via registered mode_q:
  - Manual->scan: scanning starts from the last legal manual channel (ch already holds it) with dwell=0. No wrap on the entry edge.
  - Scan->manual: that edge already uses sel; ch and dwell are overwritten per manual rules.
- Simultaneous mode change and enable=0: mode_q still updates, nothing else moves.
- Reset mid-scan: immediate return to reset values; scan restarts at channel 0.
- in_bus changes mid-dwell are reflected on the next edge; each edge samples live data.
- DWELL=1: channel advances every enabled edge; the dwell register may be optimised away.

Decomposition:
- Package multiplexer_pkg:
  - MODE_MANUAL=1'b0, MODE_SCAN=1'b1 constants.
  - Helper function for the clog2-based SEL_W.
- Sub-module scan_counter (parameters CHANNELS, DWELL):
  - Inputs: clk, rst, enable, load, load_val.
  - Outputs: ch, wrap_next.
  - Holds the ch/dwell state and wrap detection.
- Top level holds the data mux (indexed part-select), output registers and mode handling.

Test Plan (WIDTH=8, CHANNELS=4, DWELL=2 unless noted):
- Async reset: assert rst between edges while out=8'hA5 -> out=0, out_ch=0, out_valid=0 immediately, before the next edge.
- Manual select: in_bus={8'h44,8'h33,8'h22,8'h11}, mode=0, sel=2, enable=1 -> after one edge out=8'h33, out_ch=2, out_valid=1.
- Scan sequence from reset, enable held 1 -> out_ch sequence 0,0,1,1,2,2,3,3,0. wrap=1 only in the cycle out_ch first returns to 0.
- Enable gap: in scan, drop enable for 3 cycles mid-dwell on channel 1 -> out holds, out_valid=0, wrap=0. After re-enable, the remaining dwell cycle on channel 1 completes, then channel 2.
- Mode switch: manual at sel=3, then mode=1 -> scan emits 3,3,0 with wrap=1 on the 3->0 step. Switching back to manual with sel=1 -> out_ch=1 after the next edge.
- Illegal select (CHANNELS=3, DWELL=1): sel=3 in manual -> out holds previous value, out_valid=0. Scan cycles 0,1,2,0 with a wrap pulse at each 2->0.
